// File: rtl/proj1_alu_wb_if.sv
// Bundle between proj1_alu and its writeback stage: the result handshake, register
// addresses, ALU flags, and the operand/carry feedback returned to the ALU.
interface proj1_alu_wb_if #(
    parameter int AW = 5
);
    logic          valid_i;
    logic          ready_o;
    logic [7:0]    opcode_i;
    logic [AW-1:0] rd_addr_i;
    logic [AW-1:0] rr_addr_i;
    logic [15:0]   data_i;
    logic          co_i;
    logic          zo_i;
    logic          no_i;
    logic [7:0]    rd_data_o;
    logic [7:0]    rr_data_o;
    logic          ci_o;
    logic [2:0]    sreg_o;
    logic          busy_o;
    logic          wb_done_o;

    modport master (
        output valid_i, opcode_i, rd_addr_i, rr_addr_i, data_i, co_i, zo_i, no_i,
        input  ready_o, rd_data_o, rr_data_o, ci_o, sreg_o, busy_o, wb_done_o
    );

    modport slave (
        input  valid_i, opcode_i, rd_addr_i, rr_addr_i, data_i, co_i, zo_i, no_i,
        output ready_o, rd_data_o, rr_data_o, ci_o, sreg_o, busy_o, wb_done_o
    );
endinterface

// File: rtl/proj1_alu_wb.sv
// Writeback/status stage behind proj1_alu: 8-bit register file, N/Z/C status, two-cycle MUL retire.
// Optional same-cycle read bypass is enabled by defining PROJ1_ALU_WB_BYPASS_EN.
module proj1_alu_wb #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input logic           clk,
    input logic           rst,
    proj1_alu_wb_if.slave bus
);
    // state  | meaning
    // IDLE   | accepting results; non-MUL instructions retire at the accepting edge
    // WR_HI  | writing the latched MUL high byte; upstream is stalled
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WR_HI = 1'b1;

    logic [0:0]    state;
    logic [7:0]    regs [NREGS];
    logic [7:0]    hi_byte;
    logic [AW-1:0] hi_addr;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          wb_done;

    logic [3:0]    op_class;
    logic          is_shift;
    logic          is_mul;
    logic          is_logic;
    logic          is_neg;
    logic          is_arith;
    logic          accept;
    logic          wr_lo;
    logic          upd_c;
    logic          n_next;
    logic          z_next;
    logic          c_next;
    logic [AW-1:0] hi_addr_next;
    logic [7:0]    rd_val;
    logic [7:0]    rr_val;
    logic          ci_val;
    logic          unused_op_low;

    assign op_class      = bus.opcode_i[7:4];
    assign unused_op_low = ^bus.opcode_i[3:0];

    always_comb begin
        is_shift = (op_class == 4'b0000);
        is_mul   = (op_class == 4'b0100);
        is_logic = (op_class == 4'b1000) || (op_class == 4'b1001) || (op_class == 4'b1010);
        is_neg   = (op_class == 4'b1011);
        is_arith = (op_class[3:2] == 2'b11);
    end

    assign accept = bus.valid_i && (state == ST_IDLE);
    // Unknown classes are still accepted and retired, they just touch nothing.
    assign wr_lo  = accept && (is_shift || is_mul || is_logic || is_neg || is_arith);
    assign upd_c  = accept && (is_shift || is_mul || is_neg || is_arith);

    assign n_next       = is_mul ? bus.data_i[15] : bus.no_i;
    assign z_next       = is_mul ? (bus.data_i == 16'h0000) : bus.zo_i;
    assign c_next       = is_mul ? bus.data_i[15] : bus.co_i;
    assign hi_addr_next = bus.rd_addr_i + AW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept && is_mul) state <= ST_WR_HI;
                ST_WR_HI: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_byte <= 8'h00;
            hi_addr <= '0;
        end else if (accept && is_mul) begin
            hi_byte <= bus.data_i[15:8];
            hi_addr <= hi_addr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (wr_lo) begin
                flag_n <= n_next;
                flag_z <= z_next;
            end
            if (upd_c) flag_c <= c_next;
        end
    end

    // A MUL signals completion only after its high byte lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wb_done <= 1'b0;
        else      wb_done <= (accept && !is_mul) || (state == ST_WR_HI);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
        end else if (wr_lo) begin
            regs[bus.rd_addr_i] <= bus.data_i[7:0];
        end else if (state == ST_WR_HI) begin
            regs[hi_addr] <= hi_byte;
        end
    end

`ifdef PROJ1_ALU_WB_BYPASS_EN
    always_comb begin
        rd_val = regs[bus.rd_addr_i];
        rr_val = regs[bus.rr_addr_i];
        ci_val = flag_c;
        if (state == ST_WR_HI) begin
            if (bus.rd_addr_i == hi_addr) rd_val = hi_byte;
            if (bus.rr_addr_i == hi_addr) rr_val = hi_byte;
        end else if (wr_lo) begin
            rd_val = bus.data_i[7:0];
            if (bus.rr_addr_i == bus.rd_addr_i) rr_val = bus.data_i[7:0];
        end
        if (upd_c) ci_val = c_next;
    end
`else
    always_comb begin
        rd_val = regs[bus.rd_addr_i];
        rr_val = regs[bus.rr_addr_i];
        ci_val = flag_c;
    end
`endif

    assign bus.rd_data_o = rd_val;
    assign bus.rr_data_o = rr_val;
    assign bus.ci_o      = ci_val;
    assign bus.sreg_o    = {flag_n, flag_z, flag_c};
    assign bus.ready_o   = (state == ST_IDLE);
    assign bus.busy_o    = (state == ST_WR_HI);
    assign bus.wb_done_o = wb_done;
endmodule

// File: tb/tb_proj1_alu_wb.sv
// Scoreboarded bench for proj1_alu_wb: expected N/Z/C queued per instruction, popped on wb_done,
// register contents compared against a reference register model through the read ports.
module tb_proj1_alu_wb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proj1_alu_wb_if #(.AW(5)) bus ();
    proj1_alu_wb #(.NREGS(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         total  = 0;
    int         bad    = 0;
    int         pulses = 0;
    int         issued = 0;
    int         pulses_at_rst;
    logic [7:0] regs_m [32];
    logic [2:0] sreg_m;
    logic [2:0] exp_q [$];
    logic [2:0] e_mon;
    logic [7:0] oplist [11];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.wb_done_o === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk("wb_spurious", 16'(bus.wb_done_o), 16'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("sreg", 16'(bus.sreg_o), 16'(e_mon));
                chk("ci", 16'(bus.ci_o), 16'(e_mon[0]));
            end
        end
    end

    task automatic model(input logic [7:0] op, input logic [4:0] rd, input logic [15:0] d,
                         input logic co, input logic zo, input logic no);
        case (op[7:4])
            4'h4: begin
                regs_m[rd]          = d[7:0];
                regs_m[5'(rd + 1)]  = d[15:8];
                sreg_m              = {d[15], d == 16'h0000, d[15]};
            end
            4'h0, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
                regs_m[rd] = d[7:0];
                sreg_m     = {no, zo, co};
            end
            4'h8, 4'h9, 4'hA: begin
                regs_m[rd]  = d[7:0];
                sreg_m[2:1] = {no, zo};
            end
            default: ;
        endcase
        exp_q.push_back(sreg_m);
        issued++;
    endtask

    task automatic send(input logic [7:0] op, input logic [4:0] rd, input logic [15:0] d,
                        input logic co, input logic zo, input logic no);
        int n = 0;
        @(negedge clk);
        while (bus.ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 16'(bus.ready_o), 16'd1);
        bus.valid_i   = 1'b1;
        bus.opcode_i  = op;
        bus.rd_addr_i = rd;
        bus.data_i    = d;
        bus.co_i      = co;
        bus.zo_i      = zo;
        bus.no_i      = no;
        model(op, rd, d, co, zo, no);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 16'(exp_q.size()), 16'd0);
        @(negedge clk);
    endtask

    task automatic check_reg(input logic [4:0] a);
        bus.rd_addr_i = a;
        bus.rr_addr_i = ~a;
        #1;
        chk($sformatf("rd_r%0d", a), 16'(bus.rd_data_o), 16'(regs_m[a]));
        chk($sformatf("rr_r%0d", 5'(~a)), 16'(bus.rr_data_o), 16'(regs_m[~a]));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        oplist = '{8'h00, 8'h40, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'h30};
        bus.valid_i   = 1'b0;
        bus.opcode_i  = 8'h00;
        bus.rd_addr_i = 5'd0;
        bus.rr_addr_i = 5'd0;
        bus.data_i    = 16'h0000;
        bus.co_i      = 1'b0;
        bus.zo_i      = 1'b0;
        bus.no_i      = 1'b0;
        for (int i = 0; i < 32; i++) regs_m[i] = 8'h00;
        sreg_m = 3'b000;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 16'(bus.ready_o), 16'd1);
        chk("rst_busy", 16'(bus.busy_o), 16'd0);
        chk("rst_done", 16'(bus.wb_done_o), 16'd0);
        chk("rst_sreg", 16'(bus.sreg_o), 16'd0);
        check_reg(5'd3);
        rst = 1'b1;

        // ADD
        send(8'hC0, 5'd3, 16'h0046, 1'b0, 1'b0, 1'b0);
        chk("add_ready", 16'(bus.ready_o), 16'd1);
        chk("add_done", 16'(bus.wb_done_o), 16'd1);
        drain();
        check_reg(5'd3);
        chk("add_sreg", 16'(bus.sreg_o), 16'(3'b000));

        // MUL with a nonzero preload in Rd+1 so the high-byte write is visible
        send(8'hC0, 5'd5, 16'h0077, 1'b0, 1'b0, 1'b0);
        send(8'h40, 5'd4, 16'h0010, 1'b0, 1'b0, 1'b0);
        chk("mul_busy", 16'(bus.busy_o), 16'd1);
        chk("mul_ready", 16'(bus.ready_o), 16'd0);
        chk("mul_nodone", 16'(bus.wb_done_o), 16'd0);
        @(posedge clk);
        #1;
        chk("mul_busy_end", 16'(bus.busy_o), 16'd0);
        chk("mul_ready_end", 16'(bus.ready_o), 16'd1);
        chk("mul_done", 16'(bus.wb_done_o), 16'd1);
        drain();
        check_reg(5'd4);
        check_reg(5'd5);

        // MUL wrap
        send(8'h40, 5'd31, 16'hA5C3, 1'b0, 1'b0, 1'b0);
        drain();
        check_reg(5'd31);
        check_reg(5'd0);
        chk("wrap_sreg", 16'(bus.sreg_o), 16'(3'b101));

        // LOGIC keeps C
        send(8'hE0, 5'd9, 16'h00FE, 1'b1, 1'b0, 1'b1);
        drain();
        chk("sub_sreg", 16'(bus.sreg_o), 16'(3'b101));
        chk("sub_ci", 16'(bus.ci_o), 16'd1);
        send(8'h80, 5'd10, 16'h0000, 1'b0, 1'b1, 1'b0);
        drain();
        chk("and_sreg", 16'(bus.sreg_o), 16'(3'b011));
        chk("and_ci", 16'(bus.ci_o), 16'd1);

        // valid during WR_HI is ignored until ready returns
        send(8'h40, 5'd6, 16'h1122, 1'b0, 1'b0, 1'b0);
        bus.valid_i   = 1'b1;
        bus.opcode_i  = 8'hC0;
        bus.rd_addr_i = 5'd7;
        bus.rr_addr_i = 5'd7;
        bus.data_i    = 16'h0055;
        bus.co_i      = 1'b0;
        bus.zo_i      = 1'b0;
        bus.no_i      = 1'b0;
        @(negedge clk);
        chk("ign_busy", 16'(bus.busy_o), 16'd1);
        chk("ign_ready", 16'(bus.ready_o), 16'd0);
        @(posedge clk);
        #1;
        chk("ign_ready_back", 16'(bus.ready_o), 16'd1);
        @(negedge clk);
        chk("ign_r7_held", 16'(bus.rr_data_o), 16'h0011);
        model(8'hC0, 5'd7, 16'h0055, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        drain();
        check_reg(5'd7);
        check_reg(5'd6);

        // SHIFT, NEG, unknown class
        send(8'h00, 5'd11, 16'h0081, 1'b1, 1'b0, 1'b1);
        send(8'hB0, 5'd12, 16'h00FF, 1'b0, 1'b0, 1'b1);
        send(8'h20, 5'd13, 16'h00AA, 1'b1, 1'b1, 1'b1);
        drain();
        check_reg(5'd11);
        check_reg(5'd12);
        check_reg(5'd13);

        // random mix
        for (int k = 0; k < 24; k++) begin
            logic [7:0] op;
            op = oplist[$urandom_range(0, 10)] | 8'($urandom_range(0, 15));
            send(op, 5'($urandom_range(0, 31)), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();
        for (int a = 0; a < 32; a++) check_reg(5'(a));
        chk("pulse_count", 16'(pulses), 16'(issued));

        // reset while WR_HI is pending
        send(8'h40, 5'd8, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("mid_busy", 16'(bus.busy_o), 16'd1);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) regs_m[i] = 8'h00;
        sreg_m = 3'b000;
        exp_q.delete();
        pulses_at_rst = pulses;
        chk("mid_rst_busy", 16'(bus.busy_o), 16'd0);
        chk("mid_rst_ready", 16'(bus.ready_o), 16'd1);
        chk("mid_rst_done", 16'(bus.wb_done_o), 16'd0);
        chk("mid_rst_sreg", 16'(bus.sreg_o), 16'd0);
        check_reg(5'd8);
        check_reg(5'd12);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_ready", 16'(bus.ready_o), 16'd1);
        chk("post_rst_pulses", 16'(pulses), 16'(pulses_at_rst));
        check_reg(5'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/proj1_alu_wb.md
Name: proj1_alu_wb

Overview:
Writeback and status stage directly downstream of proj1_alu. It holds the 8-bit general register file and the N/Z/C status register. It consumes the ALU's 16-bit result and flags, and feeds the operand read data and carry back to the ALU inputs (data_rd, data_rr, ci). Multiply results are retired as two byte writes over two cycles: low byte to Rd, high byte to Rd+1.

Parameters:
NREGS, 32, number of 8-bit registers
AW, 5, register address width; NREGS = 2**AW

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
valid_i  in  1  ALU result valid this cycle
ready_o  out  1  stage can accept a result
opcode_i  in  8  opcode of the instruction being retired, same encoding as ALU
rd_addr_i  in  AW  destination/operand-D register address
rr_addr_i  in  AW  operand-R register address
data_i  in  16  ALU result (data_o)
co_i  in  1  ALU carry out
zo_i  in  1  ALU zero out
no_i  in  1  ALU negative out
rd_data_o  out  8  regs[rd_addr_i], combinational; drives ALU data_rd
rr_data_o  out  8  regs[rr_addr_i], combinational; drives ALU data_rr
ci_o  out  1  SREG.C; drives ALU ci
sreg_o  out  3  {N,Z,C}
busy_o  out  1  high in WR_HI
wb_done_o  out  1  one-cycle pulse when an instruction has fully retired

Behaviour:
- Reset (rst=0, asynchronous): all regs 8'h00; SREG 3'b000; state IDLE; ready_o=1; busy_o=0; wb_done_o=0; hi-byte latch 0.
- States: IDLE, WR_HI. ready_o = (state==IDLE). busy_o = (state==WR_HI).
- Accept = valid_i && ready_o. valid_i while in WR_HI is ignored; upstream holds its result until ready_o=1.
- Classes, decoded from opcode_i[7:4]:
  - SHIFT = 0000
  - MUL = 0100
  - LOGIC = 1000/1001/1010
  - NEG = 1011
  - ARITH = 1100–1111
  - Any other class: accepted, no register write, no flag change, wb_done_o still pulses.
- Non-MUL accept, at the accepting edge:
  - regs[rd_addr_i] <= data_i[7:0]
  - N <= no_i
  - Z <= zo_i
  - C <= co_i for SHIFT/NEG/ARITH; C unchanged for LOGIC
  - wb_done_o=1 in the following cycle.
- MUL accept, at the accepting edge:
  - regs[rd_addr_i] <= data_i[7:0]
  - latch data_i[15:8] and (rd_addr_i+1) mod NREGS
  - N <= data_i[15]; Z <= (data_i==16'h0000); C <= data_i[15]
  - state goes to WR_HI.
- WR_HI, one cycle: regs[latched addr] <= latched hi byte; state goes to IDLE; wb_done_o=1 in the following cycle. Latency: MUL blocks the stage for exactly 1 extra cycle.
- Wrap: Rd=NREGS-1 on MUL writes the high byte to reg 0.
- Read ports are combinational on current register contents. A write becomes visible the cycle after its edge; no forwarding unless the optional feature is enabled.
- Reset mid-WR_HI: high-byte write is discarded, state returns to IDLE, no wb_done_o pulse.
- wb_done_o is registered and never high for two consecutive cycles from one instruction.

Optional Feature:
PROJ1_ALU_WB_BYPASS_EN
- Defined:
  - In WR_HI, any read port addressing the pending high-byte register returns the latched high byte.
  - In IDLE with an accept, a read port addressing rd_addr_i returns data_i[7:0] in the same cycle.
  - ci_o returns the carry being written when C updates in that cycle.
- Undefined: pure register reads, 1-cycle write-to-read visibility as above.

Test Plan:
- ADD: after reset, valid_i=1, opcode=8'hC0, rd=3, data_i=16'h0046, co/zo/no=0 -> regs[3]=8'h46, sreg_o=3'b000, wb_done_o pulse next cycle, ready_o stays 1.
- MUL: opcode=8'h40, rd=4, data_i=16'h0010 -> regs[4]=8'h10, busy_o=1 and ready_o=0 for one cycle, then regs[5]=8'h00, sreg_o=3'b000, a single wb_done_o pulse after the high write.
- MUL wrap: rd=31, data_i=16'hA5C3 -> regs[31]=8'hC3, regs[0]=8'hA5, sreg_o=3'b101.
- LOGIC holds C:
  - set C with SUB (opcode 8'hE0, co_i=1, data_i=16'h00FE, no_i=1) -> sreg_o=3'b101, ci_o=1
  - then AND (opcode 8'h80, data_i=0, zo_i=1, co_i=0) -> sreg_o=3'b011, ci_o=1.
- Busy ignore: during WR_HI of MUL rd=6, present valid_i with opcode 8'hC0, rd=7, data_i=16'h0055 -> regs[7] unchanged until the item is re-presented with ready_o=1.
- Reset mid-op: assert rst=0 while busy_o=1 -> outputs and regs return to reset values immediately; after release, ready_o=1 and no wb_done_o pulse.
